seven_segment_scan_ctrl: RTL and testbench
==========================================

# seven_segment_scan_ctrl

Time-multiplexed scan controller that shares one `seven_segment` BCD decoder among `NUM_DIGITS` common-anode/cathode digits. It cycles a digit-select one-hot, presents the selected digit's BCD nibble to the decoder's `bcd` input, and double-buffers new display data so that updates land only on frame boundaries, which prevents tearing. It sits between the system logic that produces digit values and the shared `seven_segment` decoder plus the digit-enable pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 2..8.
- `REFRESH_DIV`, default 1000: clock cycles each digit is driven; must be ≥ 2.
- `DEAD_CYCLES`, default 2: blanking cycles between digits; used only when `SEG_SCAN_DEADTIME_EN` is defined; must be ≥ 1.
- `clk` input 1: single clock; rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `digits_in` input 4*NUM_DIGITS: digit i occupies `[4i+3:4i]`; digit 0 is the rightmost digit.
- `load` input 1: one-cycle strobe that captures `digits_in` into the pending buffer.
- `blank_mask` input NUM_DIGITS: when bit i is 1, digit i's enable is suppressed during its slot. Sampled live.
- `bcd` output 4: BCD nibble driven to the shared `seven_segment` decoder.
- `digit_en` output NUM_DIGITS: one-hot, active-high digit enable; all zeros when no digit is driven.
- `update_pending` output 1: high while captured data waits for a frame boundary.
- `frame_done` output 1: one-cycle pulse marking the start of each new frame.

## Operation
- **Buffers.**
  - `pend_buf` is the pending buffer. `act_buf` is the active buffer, which is what gets displayed.
  - Both buffers reset to all zeros.
- **Capture.** `load`=1 copies `digits_in` into `pend_buf` and sets `update_pending`. If several loads arrive before a boundary, the last one wins.
- **Frame boundary.** This is the edge on which the digit index wraps from NUM_DIGITS-1 to 0.
  - If `update_pending`=1, `act_buf` takes `pend_buf` and `update_pending` clears.
  - If `load`=1 on the boundary cycle itself, `digits_in` is written straight into both buffers and `update_pending` stays 0.
- **FSM states** (register `idx` holds the current digit, 0..NUM_DIGITS-1):
  - DRIVE: `digit_en`=one-hot(idx) unless `blank_mask[idx]`=1; `bcd`=act_buf[idx]. Counter `div_cnt` runs 0..REFRESH_DIV-1. At REFRESH_DIV-1, go to DEAD (macro defined) or to DRIVE with idx+1 modulo NUM_DIGITS (macro undefined).
  - DEAD: `digit_en`=0; `bcd` already shows act_buf[idx+1]. Stay DEAD_CYCLES cycles, then enter DRIVE with idx+1.
- **Data rules.**
  - Nibbles above 9 pass through to `bcd` unmodified; decoding is the decoder's job.
  - A blanked digit still consumes its full slot, so frame period is unchanged.
- **Reset.**
  - `rst_n` low forces, asynchronously, `digit_en`=0, `bcd`=0, `frame_done`=0, `update_pending`=0, idx=0, `div_cnt`=0, both buffers=0, state=DRIVE.
  - Reset mid-frame discards pending data.

## Timing
- `bcd`, `digit_en`, `frame_done` and `update_pending` are registered and have no combinational path from inputs.
- **First edge after reset release:** `digit_en`=one-hot(0), `bcd`=act_buf[0], `frame_done`=1.
- **Digit change:** `digit_en` and `bcd` change on the same edge.
- **Frame period:** NUM_DIGITS×REFRESH_DIV cycles without the macro; NUM_DIGITS×(REFRESH_DIV+DEAD_CYCLES) with it.
- **`frame_done`:** high for exactly the first DRIVE cycle of digit 0.
- **Update latency:** `update_pending` rises the cycle after `load`. New data appears on `bcd` at the next frame_done cycle, no sooner.
- **`blank_mask`:** takes effect at the next edge.

## Configuration
- `SEG_SCAN_DEADTIME_EN` defined: the DEAD state is compiled in. After every digit slot there are DEAD_CYCLES cycles with `digit_en`=0, which removes ghosting.
- Undefined: the DEAD state and its counter are not built. Digits switch back-to-back, and `DEAD_CYCLES` is ignored.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4 and DEAD_CYCLES=2.
- **Reset, then scan with no load** → `digit_en` sequence 0001,0010,0100,1000, each held 4 cycles, `bcd`=0 throughout. `frame_done` pulses every 16 cycles (every 24 with the macro).
- **Load 16'h9831 mid-frame** → `update_pending`=1 until the next frame boundary. From that frame, `bcd` reads 1,3,8,9 for digits 0..3.
- **Load 16'h9831 then 16'h0000 within one frame** → the next frame displays 0,0,0,0 (last load wins).
- **`load` asserted on the wrap cycle with 16'h1234** → that frame immediately shows 4,3,2,1 and `update_pending` never rises.
- **`blank_mask`=4'b0100** → digit 2's slot has `digit_en`=0 but still lasts 4 cycles; the other digits are unchanged.
- **`rst_n` pulsed low during digit 2 with a load pending** → outputs go to 0 immediately. The scan restarts at digit 0 with `bcd`=0, and the pending data is lost.

Source files
------------

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl
// Time-multiplexed scan controller sharing one BCD-to-seven-segment decoder
// among NUM_DIGITS digits. Display data is double-buffered: a load lands in
// the pending buffer and is promoted to the active buffer only at a frame
// boundary, so a frame never mixes old and new digits.
//
// Optional feature: define SEG_SCAN_DEADTIME_EN to insert DEAD_CYCLES
// blanking cycles after every digit slot (anti-ghosting). Without it the
// dead-time state and counter are not built and DEAD_CYCLES is ignored.
//
// The position registers (state_r, idx_r, div_cnt_r, dead_cnt_r) describe
// the slot cycle that the output registers will present after the next
// edge. That is why the first edge after reset already shows digit 0 with
// frame_done high.
module seven_segment_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [3:0]                bcd,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      update_pending,
    output logic                      frame_done
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Elaboration-time parameter sanity checks.
    if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
        $error("seven_segment_scan_ctrl: NUM_DIGITS must be 2..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seven_segment_scan_ctrl: REFRESH_DIV must be >= 2");
    end
    if (DEAD_CYCLES < 1) begin : g_bad_dead_cycles
        $error("seven_segment_scan_ctrl: DEAD_CYCLES must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_DRIVE = 1'b0,
        ST_DEAD  = 1'b1
    } state_t;

    // Selects nibble i of a packed digit vector.
    function automatic logic [3:0] nibble_at(input logic [DW-1:0]    data,
                                             input logic [IDX_W-1:0] i);
        nibble_at = data[{i, 2'b00} +: 4];
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_next_s;
    logic [IDX_W-1:0]      idx_inc_s;
    logic [CNT_W-1:0]      div_cnt_r;
    logic [CNT_W-1:0]      div_next_s;

`ifdef SEG_SCAN_DEADTIME_EN
    localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    logic [DEAD_W-1:0]     dead_cnt_r;
    logic [DEAD_W-1:0]     dead_next_s;
`endif

    logic [DW-1:0]         act_buf_r;
    logic [DW-1:0]         act_next_s;
    logic [DW-1:0]         pend_buf_r;
    logic [DW-1:0]         pend_next_s;
    logic                  pending_r;
    logic                  pending_next_s;
    logic                  boundary_s;

    logic [NUM_DIGITS-1:0] digit_en_r;
    logic [NUM_DIGITS-1:0] en_next_s;
    logic [3:0]            bcd_r;
    logic [3:0]            bcd_next_s;
    logic                  frame_done_r;

    assign idx_inc_s  = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
    assign boundary_s = (state_r == ST_DRIVE) && (idx_r == {IDX_W{1'b0}})
                        && (div_cnt_r == {CNT_W{1'b0}});

    // Next scan position: walk the drive counter, then (optionally) dead time.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        div_next_s   = div_cnt_r;
`ifdef SEG_SCAN_DEADTIME_EN
        dead_next_s  = dead_cnt_r;
`endif
        case (state_r)
            ST_DRIVE: begin
                if (div_cnt_r == CNT_LAST) begin
                    div_next_s = {CNT_W{1'b0}};
`ifdef SEG_SCAN_DEADTIME_EN
                    state_next_s = ST_DEAD;
                    dead_next_s  = {DEAD_W{1'b0}};
`else
                    idx_next_s   = idx_inc_s;
`endif
                end else begin
                    div_next_s = div_cnt_r + CNT_W'(1);
                end
            end
            ST_DEAD: begin
`ifdef SEG_SCAN_DEADTIME_EN
                if (dead_cnt_r == DEAD_LAST) begin
                    state_next_s = ST_DRIVE;
                    idx_next_s   = idx_inc_s;
                    dead_next_s  = {DEAD_W{1'b0}};
                end else begin
                    dead_next_s = dead_cnt_r + DEAD_W'(1);
                end
`else
                state_next_s = ST_DRIVE;
`endif
            end
            default: begin
                state_next_s = ST_DRIVE;
            end
        endcase
    end

    // Scan position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_DRIVE;
            idx_r     <= {IDX_W{1'b0}};
            div_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            idx_r     <= idx_next_s;
            div_cnt_r <= div_next_s;
        end
    end

`ifdef SEG_SCAN_DEADTIME_EN
    // Dead-time counter, only present when blanking gaps are enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt_r <= {DEAD_W{1'b0}};
        end else begin
            dead_cnt_r <= dead_next_s;
        end
    end
`endif

    // Buffer update: loads go to pending, promoted only at the frame boundary.
    always_comb begin
        act_next_s     = act_buf_r;
        pend_next_s    = pend_buf_r;
        pending_next_s = pending_r;
        if (boundary_s) begin
            if (load) begin
                act_next_s     = digits_in;
                pend_next_s    = digits_in;
                pending_next_s = 1'b0;
            end else if (pending_r) begin
                act_next_s     = pend_buf_r;
                pending_next_s = 1'b0;
            end else begin
                pending_next_s = 1'b0;
            end
        end else if (load) begin
            pend_next_s    = digits_in;
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Active/pending buffers and the pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_buf_r  <= {DW{1'b0}};
            pend_buf_r <= {DW{1'b0}};
            pending_r  <= 1'b0;
        end else begin
            act_buf_r  <= act_next_s;
            pend_buf_r <= pend_next_s;
            pending_r  <= pending_next_s;
        end
    end

    // Output values for the slot cycle being entered; uses the post-update
    // active buffer so new data shows on the very frame_done cycle.
    always_comb begin
        en_next_s  = {NUM_DIGITS{1'b0}};
        bcd_next_s = nibble_at(act_next_s, idx_r);
        case (state_r)
            ST_DRIVE: begin
                if (blank_mask[idx_r]) begin
                    en_next_s = {NUM_DIGITS{1'b0}};
                end else begin
                    en_next_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
                end
            end
            ST_DEAD: begin
                bcd_next_s = nibble_at(act_next_s, idx_inc_s);
            end
            default: begin
                en_next_s = {NUM_DIGITS{1'b0}};
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en_r   <= {NUM_DIGITS{1'b0}};
            bcd_r        <= 4'h0;
            frame_done_r <= 1'b0;
        end else begin
            digit_en_r   <= en_next_s;
            bcd_r        <= bcd_next_s;
            frame_done_r <= boundary_s;
        end
    end

    assign digit_en       = digit_en_r;
    assign bcd            = bcd_r;
    assign frame_done     = frame_done_r;
    assign update_pending = pending_r;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Self-checking bench for seven_segment_scan_ctrl (4 digits, 4-cycle slots,
// 2 dead cycles when SEG_SCAN_DEADTIME_EN is defined). The reference model
// works from the cycle count since reset release: position in frame gives
// the digit and slot phase; buffers follow the load/boundary rules.
module tb_seven_segment_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int DC = 2;
`ifdef SEG_SCAN_DEADTIME_EN
    localparam int SLOT = RD + DC;
`else
    localparam int SLOT = RD;
`endif
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        update_pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_t = 0;
    logic [15:0] m_act = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_pending = 1'b0;
    logic [3:0]  m_en = 4'b0000;
    logic [3:0]  m_bcd = 4'h0;
    logic        m_fd = 1'b0;
    int          m_dig = 0;
    int          m_within = 0;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digits_in     (digits_in),
        .load          (load),
        .blank_mask    (blank_mask),
        .bcd           (bcd),
        .digit_en      (digit_en),
        .update_pending(update_pending),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_t = 0; m_act = 16'h0000; m_pend = 16'h0000; m_pending = 1'b0;
        m_en = 4'b0000; m_bcd = 4'h0; m_fd = 1'b0;
    endtask

    // One clock: model follows the edge, then move to the sampling edge.
    task automatic step();
        int p;
        @(posedge clk);
        p = m_t % FRAME;
        if (p == 0) begin
            if (load) begin
                m_act = digits_in; m_pend = digits_in; m_pending = 1'b0;
            end else if (m_pending) begin
                m_act = m_pend; m_pending = 1'b0;
            end
        end else if (load) begin
            m_pend = digits_in; m_pending = 1'b1;
        end
        m_dig = p / SLOT;
        m_within = p % SLOT;
        m_fd = (p == 0);
        if (m_within < RD) begin
            m_en  = blank_mask[m_dig] ? 4'b0000 : (4'b0001 << m_dig);
            m_bcd = m_act[4*m_dig +: 4];
        end else begin
            m_en  = 4'b0000;
            m_bcd = m_act[4*((m_dig + 1) % N) +: 4];
        end
        m_t++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({digit_en, bcd, frame_done, update_pending} !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: en=%b bcd=%h fd=%b up=%b, expected all zero",
                     digit_en, bcd, frame_done, update_pending);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (digit_en !== 4'b0001 || bcd !== 4'h0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge: en=%b bcd=%h fd=%b, expected en=0001 bcd=0 fd=1",
                     digit_en, bcd, frame_done);
        end
    endtask

    task automatic test_scan();
        int last_fd = -1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks++;
            if ({digit_en, bcd, frame_done, update_pending} !== {m_en, m_bcd, m_fd, m_pending}) begin
                errors++;
                $display("FAIL scan c=%0d: got en=%b bcd=%h fd=%b up=%b, expected en=%b bcd=%h fd=%b up=%b",
                         c, digit_en, bcd, frame_done, update_pending, m_en, m_bcd, m_fd, m_pending);
            end
            if (frame_done) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (c - last_fd != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d cycles, expected %0d", c - last_fd, FRAME);
                    end
                end
                last_fd = c;
            end
        end
    endtask

    // Run until the next edge is at frame position 'pos'.
    task automatic advance_to(input int pos);
        for (int k = 0; k < FRAME && (m_t % FRAME) != pos; k++) step();
    endtask

    // Run one whole frame from its boundary, checking digit values at slot starts.
    task automatic frame_expect(input string name, input logic [15:0] shown);
        logic [3:0] want;
        advance_to(0);
        for (int c = 0; c < FRAME; c++) begin
            step();
            checks++;
            if ({digit_en, bcd, frame_done, update_pending} !== {m_en, m_bcd, m_fd, m_pending}) begin
                errors++;
                $display("FAIL %s c=%0d: got en=%b bcd=%h fd=%b up=%b, expected en=%b bcd=%h fd=%b up=%b",
                         name, c, digit_en, bcd, frame_done, update_pending, m_en, m_bcd, m_fd, m_pending);
            end
            if (m_within == 0) begin
                want = shown[4*m_dig +: 4];
                checks++;
                if (bcd !== want) begin
                    errors++;
                    $display("FAIL %s digit%0d: got bcd=%h, expected %h", name, m_dig, bcd, want);
                end
            end
        end
    endtask

    task automatic test_load_midframe();
        advance_to(5);
        digits_in = 16'h9831; load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) begin
            checks++;
            if (update_pending !== 1'b1 || bcd !== m_bcd) begin
                errors++;
                $display("FAIL load_wait: got up=%b bcd=%h, expected up=1 bcd=%h",
                         update_pending, bcd, m_bcd);
            end
            step();
        end
        frame_expect("load_midframe", 16'h9831);
    endtask

    task automatic test_last_load_wins();
        advance_to(2);
        digits_in = 16'h9831; load = 1'b1;
        step();
        digits_in = 16'h5555; load = 1'b0;
        step(); step();
        digits_in = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (update_pending !== 1'b1) begin
            errors++;
            $display("FAIL last_load_pending: got up=%b, expected 1", update_pending);
        end
        frame_expect("last_load", 16'h0000);
    endtask

    task automatic test_load_on_wrap();
        advance_to(0);
        digits_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (bcd !== 4'h4 || update_pending !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load: got bcd=%h up=%b fd=%b, expected bcd=4 up=0 fd=1",
                     bcd, update_pending, frame_done);
        end
        for (int c = 1; c < FRAME; c++) begin
            step();
            checks++;
            if (update_pending !== 1'b0 || bcd !== m_bcd || digit_en !== m_en) begin
                errors++;
                $display("FAIL wrap_frame c=%0d: got up=%b bcd=%h en=%b, expected up=0 bcd=%h en=%b",
                         c, update_pending, bcd, digit_en, m_bcd, m_en);
            end
        end
        frame_expect("wrap_next", 16'h1234);
    endtask

    task automatic test_blank();
        int off2 = 0;
        advance_to(0);
        blank_mask = 4'b0100;
        for (int c = 0; c < FRAME; c++) begin
            step();
            if (m_dig == 2 && m_within < RD && digit_en === 4'b0000) off2++;
            checks++;
            if (digit_en !== m_en || bcd !== m_bcd || frame_done !== m_fd) begin
                errors++;
                $display("FAIL blank c=%0d: got en=%b bcd=%h fd=%b, expected en=%b bcd=%h fd=%b",
                         c, digit_en, bcd, frame_done, m_en, m_bcd, m_fd);
            end
        end
        checks++;
        if (off2 != RD) begin
            errors++;
            $display("FAIL blank_slot_len: got %0d dark cycles for digit 2, expected %0d", off2, RD);
        end
        blank_mask = 4'b0000;
    endtask

    task automatic test_reset_midframe();
        advance_to(2 * SLOT);
        digits_in = 16'hABCD; load = 1'b1;
        step();
        load = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({digit_en, bcd, frame_done, update_pending} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: en=%b bcd=%h fd=%b up=%b, expected all zero",
                     digit_en, bcd, frame_done, update_pending);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (digit_en !== 4'b0001 || bcd !== 4'h0 || frame_done !== 1'b1 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL restart: got en=%b bcd=%h fd=%b up=%b, expected en=0001 bcd=0 fd=1 up=0",
                     digit_en, bcd, frame_done, update_pending);
        end
        frame_expect("after_reset", 16'h0000);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            digits_in = 16'($urandom);
            load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            step();
            checks++;
            if ({digit_en, bcd, frame_done, update_pending} !== {m_en, m_bcd, m_fd, m_pending}) begin
                errors++;
                $display("FAIL random c=%0d: got en=%b bcd=%h fd=%b up=%b, expected en=%b bcd=%h fd=%b up=%b",
                         c, digit_en, bcd, frame_done, update_pending, m_en, m_bcd, m_fd, m_pending);
            end
        end
        load = 1'b0;
        blank_mask = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_last_load_wins();
        test_load_on_wrap();
        test_blank();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
